// File: rtl/rv32i_muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer for the execute stage.
// One shift/add (multiply) or restoring-subtract (divide) step per cycle,
// 32 steps per op. Divide-by-zero and signed overflow skip the iteration.
module rv32i_muldiv_seq (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ce,
   input  logic        i_start,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_rs1,
   input  logic [31:0] i_rs2,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic        o_force_stall,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_result
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned CW   = 6;
   localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;
   localparam logic [XLEN-1:0] ALL_ONES  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   opa;   // multiplicand, or dividend shifting out MSB-first
   logic [XLEN-1:0]   opb;   // multiplier shifting out MSB-first, or divisor
   logic [2*XLEN-1:0] acc;   // product, or {remainder, quotient}
   logic              neg;

   // accept-time decode
   logic            accept;
   logic            a_signed;
   logic            b_signed;
   logic            sign_a;
   logic            sign_b;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            neg_in;
   logic            div_zero;
   logic            div_ovf;
   logic            fast;
   logic [XLEN-1:0] fast_res;

   // per-step datapath
   logic [2*XLEN-1:0] mul_nxt;
   logic [XLEN:0]     div_part;
   logic              div_ok;
   logic [XLEN-1:0]   div_rem;
   logic [XLEN-1:0]   div_quo;
   logic [2*XLEN-1:0] step_nxt;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   fin_res;

   // Decode the incoming op: operand signedness, magnitudes, result sign, special cases
   always_comb begin
      accept   = i_start && i_ce && !i_flush;
      a_signed = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
      b_signed = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
      sign_a   = a_signed && i_rs1[XLEN-1];
      sign_b   = b_signed && i_rs2[XLEN-1];
      mag_a    = sign_a ? (~i_rs1 + 32'd1) : i_rs1;
      mag_b    = sign_b ? (~i_rs2 + 32'd1) : i_rs2;
      // remainder takes the dividend's sign; product and quotient take the xor
      neg_in   = (i_op[2] && i_op[1]) ? sign_a : (sign_a ^ sign_b);
      div_zero = i_op[2] && (i_rs2 == '0);
      div_ovf  = i_op[2] && !i_op[0] && (i_rs1 == INT_MIN) && (i_rs2 == ALL_ONES);
      fast     = div_zero || div_ovf;
      fast_res = '0;
      if (div_zero) begin
         fast_res = i_op[1] ? i_rs1 : ALL_ONES;
      end else begin
         fast_res = i_op[1] ? '0 : INT_MIN;
      end
   end

   // One iteration step and the sign-corrected final selection
   always_comb begin
      mul_nxt  = {acc[2*XLEN-2:0], 1'b0} + (opb[XLEN-1] ? {32'd0, opa} : 64'd0);
      div_part = {acc[2*XLEN-1:XLEN], opa[XLEN-1]};
      div_ok   = (div_part >= {1'b0, opb});
      // a successful trial subtract always fits in 32 bits
      div_rem  = div_ok ? (div_part[XLEN-1:0] - opb) : div_part[XLEN-1:0];
      div_quo  = {acc[XLEN-2:0], div_ok};
      step_nxt = op_q[2] ? {div_rem, div_quo} : mul_nxt;
      prod_fix = neg ? (~mul_nxt + 64'd1) : mul_nxt;
      fin_res  = '0;
      case (op_q)
         3'd0:       fin_res = prod_fix[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:       fin_res = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5: fin_res = neg ? (~div_quo + 32'd1) : div_quo;
         default:    fin_res = neg ? (~div_rem + 32'd1) : div_rem;
      endcase
   end

   // Hold the ALU stage from the accept cycle through the last CALC cycle
   always_comb begin
      o_force_stall = !i_flush && (((state == S_IDLE) && i_start && i_ce) || (state == S_CALC));
   end

   // Sequencer state, iteration registers and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_q     <= '0;
         opa      <= '0;
         opb      <= '0;
         acc      <= '0;
         neg      <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q <= i_op;
                  if (fast) begin
                     state    <= S_FINISH;
                     o_done   <= 1'b1;
                     o_result <= fast_res;
                  end else begin
                     state  <= S_CALC;
                     o_busy <= 1'b1;
                     opa    <= mag_a;
                     opb    <= mag_b;
                     acc    <= '0;
                     cnt    <= '0;
                     neg    <= neg_in;
                  end
               end
            end
            S_CALC: begin
               if (i_flush) begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end else begin
                  acc <= step_nxt;
                  cnt <= cnt + CW'(1);
                  if (op_q[2]) begin
                     opa <= {opa[XLEN-2:0], 1'b0};
                  end else begin
                     opb <= {opb[XLEN-2:0], 1'b0};
                  end
                  if (cnt == LAST_STEP) begin
                     state    <= S_FINISH;
                     o_busy   <= 1'b0;
                     o_done   <= 1'b1;
                     o_result <= fin_res;
                  end
               end
            end
            S_FINISH: begin
               // i_start still belongs to the completing instruction here
               if (i_flush || !i_stall) begin
                  state  <= S_IDLE;
                  o_done <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
               o_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_muldiv_seq.sv
// Directed + random bench for rv32i_muldiv_seq with a result scoreboard.
module tb_rv32i_muldiv_seq;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_ce;
   logic        i_start;
   logic [2:0]  i_op;
   logic [31:0] i_rs1;
   logic [31:0] i_rs2;
   logic        i_stall;
   logic        i_flush;
   logic        o_force_stall;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_result;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   rv32i_muldiv_seq dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_ce          (i_ce),
      .i_start       (i_start),
      .i_op          (i_op),
      .i_rs1         (i_rs1),
      .i_rs2         (i_rs2),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .o_force_stall (o_force_stall),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_result      (o_result)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference RV32M semantics from wide arithmetic
   function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] za, zb, sa, sb, p;
      logic signed [31:0] as, bs, r;
      za = {32'd0, a};
      zb = {32'd0, b};
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      as = a;
      bs = b;
      case (op)
         3'd0: begin p = za * zb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * zb; return p[63:32]; end
         3'd3: begin p = za * zb; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            r = as / bs; return r;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            r = as % bs; return r;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
      return 33;
   endfunction

   // Drive one op, wait for completion, check result/timing, optionally stall FINISH
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input int stall_n);
      int lat = 0, fs = 0, bz = 0;
      logic seen = 1'b0;
      logic [31:0] want, held;
      exp_q.push_back(exp);
      i_op = op; i_rs1 = a; i_rs2 = b; i_ce = 1'b1; i_start = 1'b1;
      #1;
      while (lat < 100 && !seen) begin
         if (o_force_stall) fs++;
         tick();
         lat++;
         if (o_busy) bz++;
         if (o_done) seen = 1'b1;
      end
      want = exp_q.pop_front();
      if (!seen) begin
         chk({tag, "_timeout"}, 32'(lat), 32'(exp_lat));
         i_start = 1'b0;
         return;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_result"}, o_result, want);
      chk({tag, "_stall_cycles"}, 32'(fs), 32'(exp_lat));
      chk({tag, "_busy_cycles"}, 32'(bz), 32'(exp_lat - 1));
      chk({tag, "_fs_in_finish"}, 32'(o_force_stall), 32'd0);
      held = o_result;
      i_stall = 1'b1;
      for (int k = 0; k < stall_n; k++) begin
         tick();
         chk({tag, "_done_held"}, 32'(o_done), 32'd1);
         chk({tag, "_result_held"}, o_result, held);
      end
      i_stall = 1'b0;
      tick();
      chk({tag, "_done_clear"}, 32'(o_done), 32'd0);
      chk({tag, "_no_reaccept"}, 32'(o_busy), 32'd0);
      i_start = 1'b0;
      #1;
      chk({tag, "_fs_idle"}, 32'(o_force_stall), 32'd0);
   endtask

   initial begin
      logic [31:0] prev, a, b;
      logic [2:0]  op;
      logic        bad;
      i_rst_n = 1'b0; i_ce = 1'b0; i_start = 1'b0; i_op = '0;
      i_rs1 = '0; i_rs2 = '0; i_stall = 1'b0; i_flush = 1'b0;
      #12;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_result", o_result, 32'd0);
      chk("rst_fs", 32'(o_force_stall), 32'd0);
      i_rst_n = 1'b1;
      tick();

      run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
      run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, 0);
      run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
      run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
      run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);
      run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33, 0);
      run_op("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
      run_op("rem_z", 3'd6, 32'd5, 32'd0, 32'd5, 1, 0);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

      // Flush mid-multiply
      prev = o_result;
      i_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd5; i_ce = 1'b1; i_start = 1'b1;
      #1;
      chk("fl_fs_accept", 32'(o_force_stall), 32'd1);
      tick();
      repeat (9) tick();
      chk("fl_busy_before", 32'(o_busy), 32'd1);
      i_flush = 1'b1;
      #1;
      chk("fl_fs_low", 32'(o_force_stall), 32'd0);
      tick();
      chk("fl_busy", 32'(o_busy), 32'd0);
      chk("fl_done", 32'(o_done), 32'd0);
      chk("fl_result", o_result, prev);
      i_flush = 1'b0; i_start = 1'b0;
      bad = 1'b0;
      repeat (40) begin
         tick();
         if (o_done || o_busy) bad = 1'b1;
      end
      chk("fl_no_done", 32'(bad), 32'd0);
      run_op("divu_after_fl", 3'd5, 32'd9, 32'd3, 32'd3, 33, 0);

      // Flush together with start in IDLE
      i_op = 3'd0; i_rs1 = 32'd2; i_rs2 = 32'd2; i_start = 1'b1; i_flush = 1'b1;
      #1;
      chk("fs_flush_start", 32'(o_force_stall), 32'd0);
      tick();
      chk("flst_busy", 32'(o_busy), 32'd0);
      chk("flst_done", 32'(o_done), 32'd0);
      i_start = 1'b0; i_flush = 1'b0;

      // Clock enable low blocks accept
      i_ce = 1'b0; i_start = 1'b1;
      #1;
      chk("ce_fs", 32'(o_force_stall), 32'd0);
      tick();
      chk("ce_busy", 32'(o_busy), 32'd0);
      i_start = 1'b0; i_ce = 1'b1;

      // Random ops against the reference
      for (int k = 0; k < 10; k++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (k % 4 == 1) b = b & 32'h0000_00FF;
         if (k == 3) b = 32'd0;
         run_op("rand", op, a, b, ref_fn(op, a, b), lat_of(op, a, b), 0);
      end

      // Stall held in FINISH
      run_op("mul_stall", 3'd0, 32'd123, 32'd456, 32'd56088, 33, 4);

      // Async reset mid-CALC
      i_op = 3'd0; i_rs1 = 32'd9; i_rs2 = 32'd9; i_start = 1'b1;
      tick();
      repeat (5) tick();
      chk("rs_busy_before", 32'(o_busy), 32'd1);
      #2;
      i_start = 1'b0;
      i_rst_n = 1'b0;
      #1;
      chk("rs_busy", 32'(o_busy), 32'd0);
      chk("rs_done", 32'(o_done), 32'd0);
      chk("rs_result", o_result, 32'd0);
      chk("rs_fs", 32'(o_force_stall), 32'd0);
      i_rst_n = 1'b1;
      tick();
      chk("rs_idle", 32'(o_busy), 32'd0);
      run_op("divu_after_rst", 3'd5, 32'd50, 32'd5, 32'd10, 33, 0);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32i_muldiv_seq.md
# rv32i_muldiv_seq

Multi-cycle RV32M multiply/divide sequencer for the execute stage. It runs beside the ALU stage. When the decoded instruction is an M-extension op, the block accepts the operands, iterates for 32 cycles using a shared shift/add datapath, and holds the ALU stage through its force-stall input until the result is ready. The result is handed over in a single completion cycle and is muxed into the stage's rd/y path.

## Interface
- No parameters. Data width is fixed at 32.
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_ce  in  1  execute-stage clock enable; an op is accepted only when high.
- i_start  in  1  current execute-stage instruction is an M-extension op.
- i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1  in  32  operand A (multiplicand / dividend).
- i_rs2  in  32  operand B (multiplier / divisor).
- i_stall  in  1  downstream stall; holds the completion cycle.
- i_flush  in  1  flush execute stage; aborts any op in progress.
- o_force_stall  out  1  combinational; drives the ALU stage force-stall input.
- o_busy  out  1  registered; high in CALC.
- o_done  out  1  registered; high in FINISH. o_result is valid while it is high.
- o_result  out  32  registered result; holds its value between completions.

## Operation
- States: IDLE, CALC, FINISH. A 6-bit iteration counter counts 0..31.
- **IDLE → CALC.** Transition when i_start && i_ce && !i_flush and the op is not a special case.
  - Latch magnitudes of the operands. An operand is signed for MULH (both), MULHSU (rs1 only), DIV and REM (both).
  - Latch the result sign: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
  - Clear the 64-bit accumulator/remainder and the counter.
- **IDLE → FINISH (fast path).** Used for the special cases below, with the result loaded directly. No CALC cycles.
  - Divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = i_rs1.
  - Signed overflow (DIV/REM, rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- **CALC, multiply.** One shift-add step per cycle on the unsigned magnitudes, producing a 64-bit product.
- **CALC, divide.** One restoring-division step per cycle, producing a 32-bit quotient and a 32-bit remainder.
- **CALC → FINISH.** Taken after the step with counter = 31. o_result is loaded in the same edge:
  - apply two's-complement negation if the latched sign is set;
  - select: MUL → product[31:0]; MULH/MULHSU/MULHU → product[63:32]; DIV/DIVU → quotient; REM/REMU → remainder.
- **FINISH.** Stay in FINISH while i_stall is high. Otherwise go to IDLE.
  - i_start is still high in this cycle for the same instruction and is ignored. There is no re-accept from FINISH.
- **o_force_stall** = !i_flush && ((state==IDLE && i_start && i_ce) || state==CALC).
  - It is low in FINISH, so the ALU stage captures o_result on that edge.
- **i_flush** in any state: next state is IDLE, and o_done is not raised for the aborted op. o_result is unchanged.
- **Reset values:**
  - state IDLE, counter 0;
  - o_busy 0, o_done 0, o_result 0x00000000;
  - o_force_stall 0 whenever i_start is low.
- Asynchronous reset mid-operation returns to IDLE immediately and discards the op.

## Timing
- The op is accepted at edge N, the cycle in which i_start && i_ce is sampled in IDLE.
- Normal path: CALC spans cycles N+1..N+32; FINISH and o_done are high in cycle N+33. Latency is 33 cycles; the ALU stage is stalled for 33 cycles including the accept cycle.
- Fast path: FINISH/o_done in cycle N+1. Latency is 1 cycle.
- o_done is a one-cycle pulse unless extended by i_stall. o_result is stable throughout.
- Back-to-back ops: a new accept is possible in the cycle after FINISH exits to IDLE, giving a minimum of 34 cycles between done pulses.
- Flush and start together in IDLE: no accept, and o_force_stall stays low.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → o_done at accept+33, o_result 0xFFFFFFEB. o_force_stall high for exactly 33 cycles, o_busy high for 32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Fast paths: DIVU 5/0 → 0xFFFFFFFF at accept+1; REM 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same → 0. No o_busy for any of these.
- Assert i_flush at accept+10 of a MUL → IDLE next cycle, no o_done, o_result unchanged. A following DIVU 9/3 completes normally → 3.
- Assert i_stall for 4 cycles in FINISH → o_done held for 5 cycles with constant o_result, and no second accept. Then pulse i_rst_n low mid-CALC → all outputs return to reset values asynchronously.
